// File: rtl/reg_fifo_sc.sv
// Single-clock flip-flop FIFO with a registered read port and registered status flags.
// Flags and CNT are computed from the next count, so they change on the same edge as the data.
module reg_fifo_sc #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic                           CK,
  input  logic                           CD,
  input  logic [WIDTH-1:0]               DI,
  input  logic                           WE,
  input  logic                           RE,
  output logic [WIDTH-1:0]               DO,
  output logic                           EF,
  output logic                           FF,
  output logic                           AE,
  output logic                           AF,
  output logic                           OVF,
  output logic                           UNF,
  output logic [$clog2(DEPTH+1)-1:0]     CNT
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTRW-1:0] PTR_MAX  = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_LVL   = CNTW'(AF_LEVEL);
  localparam logic [CNTW-1:0] AE_LVL   = CNTW'(AE_LEVEL);
  localparam logic            AF_RST   = (AF_LEVEL == 0);

  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             ef_q, ef_d;
  logic             ff_q, ff_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr_en;
  logic rd_en;

  always_comb begin
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    rd_en  = RE && !ef_q;
    wr_en  = WE && (!ff_q || rd_en);

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    do_d   = do_q;

    if (wr_en) begin
      mem_d[wptr_q] = DI;
      wptr_d        = (wptr_q == PTR_MAX) ? '0 : wptr_q + PTRW'(1);
    end

    if (rd_en) begin
      do_d   = mem_q[rptr_q];
      rptr_d = (rptr_q == PTR_MAX) ? '0 : rptr_q + PTRW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase

    ef_d  = (cnt_d == '0);
    ff_d  = (cnt_d == CNT_FULL);
    af_d  = (cnt_d >= AF_LVL);
    ae_d  = (cnt_d <= AE_LVL);
    ovf_d = ovf_q | (WE & ff_q & ~RE);
    unf_d = unf_q | (RE & ef_q);
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      do_q   <= '0;
      ef_q   <= 1'b1;
      ff_q   <= 1'b0;
      ae_q   <= 1'b1;
      af_q   <= AF_RST;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      do_q   <= do_d;
      ef_q   <= ef_d;
      ff_q   <= ff_d;
      ae_q   <= ae_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately left out of the clear.
  always_ff @(posedge CK) begin
    mem_q <= mem_d;
  end

  assign DO  = do_q;
  assign EF  = ef_q;
  assign FF  = ff_q;
  assign AE  = ae_q;
  assign AF  = af_q;
  assign OVF = ovf_q;
  assign UNF = unf_q;
  assign CNT = cnt_q;

endmodule

// File: tb/tb_reg_fifo_sc.sv
// Directed bench for reg_fifo_sc: a DEPTH=4 instance for the main tests and a DEPTH=3 instance for wrap.
module tb_reg_fifo_sc;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // Instance A: DEPTH=4, AF=3, AE=1
  logic       cd_a, we_a, re_a;
  logic [3:0] di_a, do_a;
  logic       ef_a, ff_a, ae_a, af_a, ovf_a, unf_a;
  logic [2:0] cnt_a;

  // Instance B: DEPTH=3, AF=2, AE=1
  logic       cd_b, we_b, re_b;
  logic [3:0] di_b, do_b;
  logic       ef_b, ff_b, ae_b, af_b, ovf_b, unf_b;
  logic [1:0] cnt_b;

  reg_fifo_sc #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .CK(ck), .CD(cd_a), .DI(di_a), .WE(we_a), .RE(re_a), .DO(do_a),
    .EF(ef_a), .FF(ff_a), .AE(ae_a), .AF(af_a), .OVF(ovf_a), .UNF(unf_a), .CNT(cnt_a)
  );

  reg_fifo_sc #(.WIDTH(4), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1)) dut_b (
    .CK(ck), .CD(cd_b), .DI(di_b), .WE(we_b), .RE(re_b), .DO(do_b),
    .EF(ef_b), .FF(ff_b), .AE(ae_b), .AF(af_b), .OVF(ovf_b), .UNF(unf_b), .CNT(cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, one set per instance (index 0 = A, 1 = B)
  logic [3:0] sb_a [$];
  logic [3:0] sb_b [$];
  int         m_cnt [2];
  logic [3:0] m_do  [2];
  logic       m_ovf [2];
  logic       m_unf [2];
  int         m_dep [2] = '{4, 3};
  int         m_af  [2] = '{3, 2};
  int         m_ae  [2] = '{1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int s, input string tag);
    logic [3:0] o_do;
    logic       o_ef, o_ff, o_ae, o_af, o_ovf, o_unf;
    int         o_cnt;
    if (s == 0) begin
      o_do = do_a; o_ef = ef_a; o_ff = ff_a; o_ae = ae_a; o_af = af_a;
      o_ovf = ovf_a; o_unf = unf_a; o_cnt = int'(cnt_a);
    end else begin
      o_do = do_b; o_ef = ef_b; o_ff = ff_b; o_ae = ae_b; o_af = af_b;
      o_ovf = ovf_b; o_unf = unf_b; o_cnt = int'(cnt_b);
    end
    chk({tag, ".DO"},  32'(o_do),  32'(m_do[s]));
    chk({tag, ".CNT"}, 32'(o_cnt), 32'(m_cnt[s]));
    chk({tag, ".EF"},  32'(o_ef),  32'(m_cnt[s] == 0));
    chk({tag, ".FF"},  32'(o_ff),  32'(m_cnt[s] == m_dep[s]));
    chk({tag, ".AF"},  32'(o_af),  32'(m_cnt[s] >= m_af[s]));
    chk({tag, ".AE"},  32'(o_ae),  32'(m_cnt[s] <= m_ae[s]));
    chk({tag, ".OVF"}, 32'(o_ovf), 32'(m_ovf[s]));
    chk({tag, ".UNF"}, 32'(o_unf), 32'(m_unf[s]));
  endtask

  task automatic model_clear(input int s);
    m_cnt[s] = 0; m_do[s] = 4'h0; m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
    if (s == 0) sb_a.delete(); else sb_b.delete();
  endtask

  // Asynchronous clear pulsed between clock edges; outputs checked before any edge.
  task automatic pulse_cd(input int s, input string tag);
    #2;
    if (s == 0) cd_a = 1'b1; else cd_b = 1'b1;
    #1;
    model_clear(s);
    chk_all(s, tag);
    if (s == 0) cd_a = 1'b0; else cd_b = 1'b0;
  endtask

  // One clock: drive inputs, predict, sample 1 time unit after the edge.
  task automatic cyc(input int s, input logic we, input logic re, input logic [3:0] di,
                     input string tag);
    bit rd, wr;
    if (s == 0) begin we_a = we; re_a = re; di_a = di; end
    else        begin we_b = we; re_b = re; di_b = di; end
    rd = re && (m_cnt[s] != 0);
    wr = we && ((m_cnt[s] != m_dep[s]) || rd);
    if (we && (m_cnt[s] == m_dep[s]) && !re) m_ovf[s] = 1'b1;
    if (re && (m_cnt[s] == 0))               m_unf[s] = 1'b1;
    if (rd) m_do[s] = (s == 0) ? sb_a.pop_front() : sb_b.pop_front();
    if (wr) begin
      if (s == 0) sb_a.push_back(di); else sb_b.push_back(di);
    end
    m_cnt[s] = m_cnt[s] + int'(wr) - int'(rd);
    @(posedge ck);
    #1;
    if (s == 0) begin we_a = 1'b0; re_a = 1'b0; end
    else        begin we_b = 1'b0; re_b = 1'b0; end
    chk_all(s, tag);
  endtask

  initial begin
    cd_a = 1'b1; we_a = 1'b0; re_a = 1'b0; di_a = 4'h0;
    cd_b = 1'b1; we_b = 1'b0; re_b = 1'b0; di_b = 4'h0;
    model_clear(0);
    model_clear(1);
    #1;
    chk_all(0, "reset_a");
    chk_all(1, "reset_b");
    @(posedge ck); #1;
    cd_a = 1'b0; cd_b = 1'b0;
    pulse_cd(0, "cd_pulse");

    // Fill and drain
    cyc(0, 1, 0, 4'hA, "fill0");
    cyc(0, 1, 0, 4'hB, "fill1");
    cyc(0, 1, 0, 4'hC, "fill2");
    cyc(0, 1, 0, 4'hD, "fill3");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'h0, $sformatf("drain%0d", i));
    cyc(0, 0, 0, 4'h0, "idle_hold");

    // Overflow: 0xE must never come back out
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'hA + 4'(i), $sformatf("refill%0d", i));
    cyc(0, 1, 0, 4'hE, "overflow");
    cyc(0, 0, 0, 4'h0, "ovf_sticky");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'h0, $sformatf("ovf_drain%0d", i));
    cyc(0, 0, 1, 4'h0, "underflow");
    cyc(0, 1, 1, 4'h9, "both_empty");
    cyc(0, 0, 1, 4'h0, "both_empty_rd");

    // Simultaneous read/write while full
    pulse_cd(0, "cd_clear1");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'hA + 4'(i), $sformatf("full_fill%0d", i));
    for (int i = 1; i <= 6; i++) cyc(0, 1, 1, 4'(i), $sformatf("full_rw%0d", i));
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'h0, $sformatf("full_drain%0d", i));

    // Reset mid-stream with two words held
    cyc(0, 1, 0, 4'h3, "mid_w0");
    cyc(0, 1, 0, 4'h4, "mid_w1");
    pulse_cd(0, "mid_reset");
    cyc(0, 1, 0, 4'h5, "post_w");
    cyc(0, 0, 1, 4'h0, "post_r");
    cyc(0, 0, 1, 4'h0, "post_unf");

    // Wrap on DEPTH=3: write then read, seven times
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 0, 4'(i + 1), $sformatf("wrap_w%0d", i));
      cyc(1, 0, 1, 4'h0,      $sformatf("wrap_r%0d", i));
    end
    // Wrap with the FIFO kept partly full and at full
    cyc(1, 1, 0, 4'h8, "wrap_f0");
    cyc(1, 1, 0, 4'h9, "wrap_f1");
    cyc(1, 1, 0, 4'hA, "wrap_f2");
    cyc(1, 1, 1, 4'hB, "wrap_f3");
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'h0, $sformatf("wrap_d%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
